// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N:1 mux/arbiter family.
package mux_pkg;

    // Operating modes of mux_arb_nx1
    localparam int unsigned MODE_SELECT = 0;
    localparam int unsigned MODE_RR     = 1;

    // Upper bound on channel count, sizes the helper search range
    localparam int unsigned MAX_LOG2 = 31;

    // Ceiling log2, never smaller than 1 so index ports keep a real bit
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned bits;
        bits = 1;
        for (int unsigned b = 1; b <= MAX_LOG2; b++) begin
            if ((64'd1 << (b - 1)) < 64'(value)) begin
                bits = b;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/rr_grant_nx1.sv
// Rotate-priority encoder: first requester after ptr, wrapping modulo N.
module rr_grant_nx1 #(
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant,
    output logic             grant_valid
);

    logic [SEL_W-1:0] idx;

    // Walk ptr+1 .. ptr+N (mod N) and keep the first requesting channel
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = SEL_W'((32'(ptr) + k) % N);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

endmodule

// File: rtl/mux_arb_nx1.sv
// Registered N:1 multiplexer with valid/ready handshakes; explicit select
// or round-robin arbitration, one output register stage.
module mux_arb_nx1
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = clog2_min1(N),
    parameter int unsigned MODE  = MODE_SELECT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_src,
    output logic               sel_err
);

    logic             can_load;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             xfer;
    logic             sel_bad;
    logic [WIDTH-1:0] grant_data;

    assign can_load = !out_valid || out_ready;

    if (MODE == MODE_RR) begin : g_rr
        logic [SEL_W-1:0] rr_ptr;
        logic             unused_sel;

        // sel has no role when arbitrating
        assign unused_sel = ^sel;
        assign sel_bad    = 1'b0;

        rr_grant_nx1 #(
            .N     (N),
            .SEL_W (SEL_W)
        ) u_rr_grant (
            .req         (in_valid),
            .ptr         (rr_ptr),
            .grant       (grant),
            .grant_valid (grant_valid)
        );

        // Pointer remembers the last served channel; moves only on a transfer
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rr_ptr <= SEL_W'(N - 1);
            end else if (xfer) begin
                rr_ptr <= grant;
            end
        end
    end else begin : g_sel
        assign grant       = sel;
        assign grant_valid = (32'(sel) < N);
        assign sel_bad     = !grant_valid;
    end

    // One-hot ready toward the granted channel when the output stage can load
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            in_ready[i] = can_load && grant_valid && (32'(grant) == i);
        end
    end

    assign xfer = |(in_ready & in_valid);

    // Data path mux; compares against each legal index so an out-of-range
    // grant can never address past the packed input bus
    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(grant) == i) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register: load on transfer, drop valid on consume without refill
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_src   <= grant;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Illegal-select flag, raised each cycle a bad sel meets a valid input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= sel_bad && (|in_valid);
        end
    end

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Directed bench for mux_arb_nx1: select mode (N=4, N=3) and
// round-robin mode (N=4, N=3).
module tb_mux_arb_nx1;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    // Instance A: MODE 0, N=4
    logic [127:0] a_in_data;
    logic [3:0]   a_in_valid, a_in_ready;
    logic [1:0]   a_sel, a_out_src;
    logic [31:0]  a_out_data;
    logic         a_out_valid, a_out_ready, a_sel_err;

    // Instance B: MODE 0, N=3
    logic [95:0]  b_in_data;
    logic [2:0]   b_in_valid, b_in_ready;
    logic [1:0]   b_sel, b_out_src;
    logic [31:0]  b_out_data;
    logic         b_out_valid, b_out_ready, b_sel_err;

    // Instance C: MODE 1, N=4
    logic [127:0] c_in_data;
    logic [3:0]   c_in_valid, c_in_ready;
    logic [1:0]   c_sel, c_out_src;
    logic [31:0]  c_out_data;
    logic         c_out_valid, c_out_ready, c_sel_err;

    // Instance D: MODE 1, N=3
    logic [95:0]  d_in_data;
    logic [2:0]   d_in_valid, d_in_ready;
    logic [1:0]   d_sel, d_out_src;
    logic [31:0]  d_out_data;
    logic         d_out_valid, d_out_ready, d_sel_err;

    mux_arb_nx1 #(.WIDTH(32), .N(4), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_src(a_out_src),
        .sel_err(a_sel_err));

    mux_arb_nx1 #(.WIDTH(32), .N(3), .MODE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_src(b_out_src),
        .sel_err(b_sel_err));

    mux_arb_nx1 #(.WIDTH(32), .N(4), .MODE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_src(c_out_src),
        .sel_err(c_sel_err));

    mux_arb_nx1 #(.WIDTH(32), .N(3), .MODE(1)) u_d (
        .clk(clk), .rst_n(rst_n), .in_data(d_in_data), .in_valid(d_in_valid),
        .in_ready(d_in_ready), .sel(d_sel), .out_data(d_out_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_src(d_out_src),
        .sel_err(d_sel_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL reset_a_valid: got %b want 0", a_out_valid); end
        tests++; if (a_out_data !== 32'h0) begin fails++; $display("FAIL reset_a_data: got %h want 0", a_out_data); end
        tests++; if (a_out_src !== 2'd0) begin fails++; $display("FAIL reset_a_src: got %0d want 0", a_out_src); end
        tests++; if (a_sel_err !== 1'b0) begin fails++; $display("FAIL reset_a_sel_err: got %b want 0", a_sel_err); end
        tests++; if (c_out_valid !== 1'b0) begin fails++; $display("FAIL reset_c_valid: got %b want 0", c_out_valid); end
        rst_n = 1'b1;
    endtask

    task automatic test_select_sweep();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h12345678; exp_w[1] = 32'h87654321;
        exp_w[2] = 32'hABCDEFAB; exp_w[3] = 32'hFEDCBAFE;
        @(posedge clk); #1;
        a_in_data   = {32'hFEDCBAFE, 32'hABCDEFAB, 32'h87654321, 32'h12345678};
        a_in_valid  = 4'b1111;
        a_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_sel = 2'(k);
            #1;
            tests++; if (a_in_ready !== 4'(1 << k)) begin fails++; $display("FAIL sweep_ready[%0d]: got %b want %b", k, a_in_ready, 4'(1 << k)); end
            @(posedge clk); #1;
            tests++; if (a_out_data !== exp_w[k]) begin fails++; $display("FAIL sweep_data[%0d]: got %h want %h", k, a_out_data, exp_w[k]); end
            tests++; if (a_out_src !== 2'(k)) begin fails++; $display("FAIL sweep_src[%0d]: got %0d want %0d", k, a_out_src, k); end
            tests++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL sweep_valid[%0d]: got %b want 1", k, a_out_valid); end
        end
        a_in_valid = 4'b0000;
        @(posedge clk); #1;
        tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL sweep_drain_valid: got %b want 0", a_out_valid); end
        tests++; if (a_out_data !== 32'hFEDCBAFE) begin fails++; $display("FAIL sweep_drain_data: got %h want FEDCBAFE", a_out_data); end
    endtask

    task automatic test_stall_release();
        a_in_valid  = 4'b1111;
        a_out_ready = 1'b1;
        a_sel       = 2'd2;
        @(posedge clk); #1;
        tests++; if (a_out_data !== 32'hABCDEFAB) begin fails++; $display("FAIL stall_first_data: got %h want ABCDEFAB", a_out_data); end
        a_out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            a_sel = 2'(k);
            #1;
            tests++; if (a_in_ready !== 4'b0000) begin fails++; $display("FAIL stall_ready[%0d]: got %b want 0000", k, a_in_ready); end
            @(posedge clk); #1;
            tests++; if (a_out_data !== 32'hABCDEFAB) begin fails++; $display("FAIL stall_data[%0d]: got %h want ABCDEFAB", k, a_out_data); end
            tests++; if (a_out_src !== 2'd2) begin fails++; $display("FAIL stall_src[%0d]: got %0d want 2", k, a_out_src); end
            tests++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d]: got %b want 1", k, a_out_valid); end
        end
        a_out_ready = 1'b1;
        a_sel       = 2'd3;
        #1;
        tests++; if (a_in_ready !== 4'b1000) begin fails++; $display("FAIL release_ready: got %b want 1000", a_in_ready); end
        @(posedge clk); #1;
        tests++; if (a_out_data !== 32'hFEDCBAFE) begin fails++; $display("FAIL release_data: got %h want FEDCBAFE", a_out_data); end
        tests++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL release_valid: got %b want 1", a_out_valid); end
        a_in_valid = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic test_sel_err();
        b_in_data   = {32'hB0000002, 32'hB0000001, 32'hB0000000};
        b_in_valid  = 3'b111;
        b_out_ready = 1'b1;
        b_sel       = 2'd3;
        #1;
        tests++; if (b_in_ready !== 3'b000) begin fails++; $display("FAIL selerr_ready: got %b want 000", b_in_ready); end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            tests++; if (b_sel_err !== 1'b1) begin fails++; $display("FAIL selerr_pulse[%0d]: got %b want 1", k, b_sel_err); end
            tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL selerr_no_xfer[%0d]: got %b want 0", k, b_out_valid); end
        end
        b_in_valid = 3'b000;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            tests++; if (b_sel_err !== 1'b0) begin fails++; $display("FAIL selerr_idle[%0d]: got %b want 0", k, b_sel_err); end
        end
        b_sel      = 2'd1;
        b_in_valid = 3'b010;
        @(posedge clk); #1;
        tests++; if (b_sel_err !== 1'b0) begin fails++; $display("FAIL selerr_legal: got %b want 0", b_sel_err); end
        tests++; if (b_out_src !== 2'd1) begin fails++; $display("FAIL selerr_legal_src: got %0d want 1", b_out_src); end
        tests++; if (b_out_data !== 32'hB0000001) begin fails++; $display("FAIL selerr_legal_data: got %h want B0000001", b_out_data); end
        b_in_valid = 3'b000;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int exp_a [5] = '{0, 1, 2, 3, 0};
        int exp_b [4] = '{1, 3, 1, 3};
        c_in_data   = {32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};
        c_in_valid  = 4'b1111;
        c_out_ready = 1'b1;
        #1;
        tests++; if (c_in_ready !== 4'b0001) begin fails++; $display("FAIL rr_first_ready: got %b want 0001", c_in_ready); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            tests++; if (c_out_src !== 2'(exp_a[k])) begin fails++; $display("FAIL rr_all_src[%0d]: got %0d want %0d", k, c_out_src, exp_a[k]); end
            tests++; if (c_out_data !== 32'hC0000000 + 32'(exp_a[k])) begin fails++; $display("FAIL rr_all_data[%0d]: got %h want %h", k, c_out_data, 32'hC0000000 + 32'(exp_a[k])); end
        end
        c_in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            tests++; if (c_out_src !== 2'(exp_b[k])) begin fails++; $display("FAIL rr_alt_src[%0d]: got %0d want %0d", k, c_out_src, exp_b[k]); end
        end
        c_in_valid = 4'b0000;
        @(posedge clk); #1;
        tests++; if (c_out_valid !== 1'b0) begin fails++; $display("FAIL rr_idle_valid: got %b want 0", c_out_valid); end
        tests++; if (c_sel_err !== 1'b0) begin fails++; $display("FAIL rr_sel_err: got %b want 0", c_sel_err); end
    endtask

    task automatic test_rr_stall();
        logic [3:0] stall_v [3];
        stall_v[0] = 4'b0110; stall_v[1] = 4'b0001; stall_v[2] = 4'b1100;
        c_in_valid  = 4'b1111;
        c_out_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (c_out_src !== 2'd0) begin fails++; $display("FAIL rrstall_pre_src: got %0d want 0", c_out_src); end
        c_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            c_in_valid = stall_v[k];
            #1;
            tests++; if (c_in_ready !== 4'b0000) begin fails++; $display("FAIL rrstall_ready[%0d]: got %b want 0000", k, c_in_ready); end
            @(posedge clk); #1;
            tests++; if (c_out_data !== 32'hC0000000) begin fails++; $display("FAIL rrstall_data[%0d]: got %h want C0000000", k, c_out_data); end
            tests++; if (c_out_src !== 2'd0) begin fails++; $display("FAIL rrstall_src[%0d]: got %0d want 0", k, c_out_src); end
        end
        c_out_ready = 1'b1;
        c_in_valid  = 4'b1111;
        #1;
        tests++; if (c_in_ready !== 4'b0010) begin fails++; $display("FAIL rrstall_release_ready: got %b want 0010", c_in_ready); end
        @(posedge clk); #1;
        tests++; if (c_out_src !== 2'd1) begin fails++; $display("FAIL rrstall_release_src: got %0d want 1", c_out_src); end
        tests++; if (c_out_data !== 32'hC0000001) begin fails++; $display("FAIL rrstall_release_data: got %h want C0000001", c_out_data); end
        c_in_valid = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic test_rr_wrap();
        int exp_a [4] = '{0, 1, 2, 0};
        int exp_b [3] = '{2, 0, 2};
        d_in_data   = {32'hD0000002, 32'hD0000001, 32'hD0000000};
        d_in_valid  = 3'b111;
        d_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            tests++; if (d_out_src !== 2'(exp_a[k])) begin fails++; $display("FAIL wrap_all_src[%0d]: got %0d want %0d", k, d_out_src, exp_a[k]); end
        end
        d_in_valid = 3'b101;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            tests++; if (d_out_src !== 2'(exp_b[k])) begin fails++; $display("FAIL wrap_sparse_src[%0d]: got %0d want %0d", k, d_out_src, exp_b[k]); end
            tests++; if (d_out_data !== 32'hD0000000 + 32'(exp_b[k])) begin fails++; $display("FAIL wrap_sparse_data[%0d]: got %h want %h", k, d_out_data, 32'hD0000000 + 32'(exp_b[k])); end
        end
        d_in_valid = 3'b000;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        c_in_valid  = 4'b1111;
        c_out_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (c_out_valid !== 1'b1) begin fails++; $display("FAIL midrst_loaded: got %b want 1", c_out_valid); end
        c_out_ready = 1'b0;
        rst_n       = 1'b0;
        @(posedge clk); #1;
        tests++; if (c_out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", c_out_valid); end
        tests++; if (c_out_data !== 32'h0) begin fails++; $display("FAIL midrst_data: got %h want 0", c_out_data); end
        tests++; if (c_out_src !== 2'd0) begin fails++; $display("FAIL midrst_src: got %0d want 0", c_out_src); end
        rst_n       = 1'b1;
        c_out_ready = 1'b1;
        #1;
        tests++; if (c_in_ready !== 4'b0001) begin fails++; $display("FAIL midrst_ready: got %b want 0001", c_in_ready); end
        @(posedge clk); #1;
        tests++; if (c_out_src !== 2'd0) begin fails++; $display("FAIL midrst_first_src: got %0d want 0", c_out_src); end
        tests++; if (c_out_data !== 32'hC0000000) begin fails++; $display("FAIL midrst_first_data: got %h want C0000000", c_out_data); end
        c_in_valid = 4'b0000;
        @(posedge clk); #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        a_in_data = '0; a_in_valid = '0; a_sel = '0; a_out_ready = 1'b0;
        b_in_data = '0; b_in_valid = '0; b_sel = '0; b_out_ready = 1'b0;
        c_in_data = '0; c_in_valid = '0; c_sel = '0; c_out_ready = 1'b0;
        d_in_data = '0; d_in_valid = '0; d_sel = '0; d_out_ready = 1'b0;

        test_reset();
        test_select_sweep();
        test_stall_release();
        test_sel_err();
        test_round_robin();
        test_rr_stall();
        test_rr_wrap();
        test_reset_midstream();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_arb_nx1.md
Name: mux_arb_nx1

Overview:
- Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshakes; successor to the combinational 4x1 datapath muxes.
- Two modes: explicit select (a drop-in registered replacement for operand and writeback muxes) or round-robin arbitration (shared-resource access, e.g. the memory port between fetch and load/store).
- Single output register stage; full throughput when the consumer is ready.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels (2..16).
- SEL_W, $clog2(N) (min 1), width of select and source index.
- MODE, 0, 0 = explicit select via sel, 1 = round-robin among valid inputs.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready (combinational).
- sel  input  SEL_W  channel select, MODE 0 only (ignored in MODE 1).
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word.
- out_src  output  SEL_W  index of the channel that supplied out_data.
- sel_err  output  1  registered 1-cycle pulse: MODE 0 sel >= N while any in_valid is high.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears out_valid, out_data, out_src and sel_err to 0, and sets rr_ptr to N-1. Reset overrides any transfer in the same cycle; a word held mid-handshake is dropped.
- can_load = !out_valid || out_ready.
- Grant g (combinational):
  - MODE 0: g = sel when sel < N.
  - MODE 1: g = first index with in_valid set, searching rr_ptr+1, rr_ptr+2, ... modulo N.
- in_ready[i] = can_load && grant_valid && (i == g). All other in_ready bits are 0. At most one in_ready bit is high.
- Input transfer when in_valid[g] && in_ready[g]. At the next edge: out_data <= in_data[g], out_src <= g, out_valid <= 1.
- MODE 1: rr_ptr <= g on a transfer only. rr_ptr is unchanged on a stall or when no input is valid.
- Output consumed when out_valid && out_ready. If there is no new transfer in the same cycle, out_valid <= 0 at the next edge; out_data and out_src hold their last values.
- Simultaneous consume and transfer: the new word replaces the old one with no bubble, giving 1 word per cycle sustained.
- Latency: 1 cycle from input transfer to out_valid.
- Stall: while out_valid && !out_ready, all in_ready bits are 0 and out_data, out_src and rr_ptr are stable.
- MODE 0 with sel >= N: grant_valid = 0 and no transfer occurs. sel_err <= |in_valid at the next edge; otherwise sel_err <= 0.
- MODE 0 with sel changing while out_valid is stalled: no effect on the held word.
- MODE 1 with no valid inputs: no transfer, pointer unchanged, and out_valid falls after consumption.
- N not a power of two: wrap-around is modulo N, never modulo 2^SEL_W.
- sel_err is always 0 in MODE 1.

Decomposition:
- Shared package/header mux_pkg: MODE_SELECT=0 and MODE_RR=1 constants, plus a clog2 helper function.
- One natural sub-module: rr_grant_nx1 (combinational rotate-priority encoder: inputs req[N] and ptr, outputs grant index and grant_valid). It is instantiated only when MODE=1.
- The output register, handshake and pointer logic stay in the top module.

Test Plan:
- MODE 0, N=4, WIDTH=32, out_ready=1, in_valid=4'b1111; in_data = {FEDCBAFE, ABCDEFAB, 87654321, 12345678} (channels 3..0); sel stepped 0,1,2,3 on consecutive cycles -> out_data 12345678, 87654321, ABCDEFAB, FEDCBAFE on the four following cycles, out_src 0..3, out_valid continuously 1.
- MODE 0, hold out_ready=0 after the first word (sel=2) -> out_data stays ABCDEFAB, in_ready=0000. Raise out_ready with sel=3 -> the next cycle shows FEDCBAFE with no bubble.
- MODE 0, N=3, sel=3, in_valid=3'b111 -> no transfer, in_ready=000, sel_err=1 for exactly one cycle per cycle of the condition; with sel=3 and in_valid=000, sel_err stays 0.
- MODE 1, N=4, all in_valid=1, out_ready=1 after reset -> out_src sequence 0,1,2,3,0. With in_valid=4'b1010 -> alternates 1,3,1,3.
- MODE 1, stall with out_ready=0 for 3 cycles while in_valid changes -> rr_ptr and out_data frozen; the grant after release follows the pointer held before the stall.
- Reset mid-stream (rst_n=0 for one edge while out_valid=1, out_ready=0) -> next cycle out_valid=0, out_data=0, out_src=0; in MODE 1 the first post-reset grant goes to channel 0 when all inputs are valid.
